// File: rtl/ddr_rd_capture_if.sv
// Command, DQ pair and word-handoff bundle for the DDR read capture stage.
// The capture block takes the slave side; the controller or bench takes the master side.
interface ddr_rd_capture_if #(
  parameter int unsigned DQ_W      = 16,
  parameter int unsigned BURST_LEN = 8,
  parameter int unsigned LAT_W     = 5
);
  logic                      RD_CMD;
  logic [LAT_W-1:0]          RD_LAT;
  logic                      SLIP;
  logic [DQ_W-1:0]           Q0;
  logic [DQ_W-1:0]           Q1;
  logic [DQ_W*BURST_LEN-1:0] RDATA;
  logic                      RVALID;
  logic                      RREADY;
  logic                      BUSY;
  logic                      OVERFLOW;
  logic                      PROTO_ERR;
  logic                      CLR_FLAGS;

  modport master (
    output RD_CMD, RD_LAT, SLIP, Q0, Q1, RREADY, CLR_FLAGS,
    input  RDATA, RVALID, BUSY, OVERFLOW, PROTO_ERR
  );

  modport slave (
    input  RD_CMD, RD_LAT, SLIP, Q0, Q1, RREADY, CLR_FLAGS,
    output RDATA, RVALID, BUSY, OVERFLOW, PROTO_ERR
  );
endinterface

// File: rtl/ddr_rd_capture.sv
// DDR read-data capture: delays each read command to its data window, assembles
// the burst from Q0/Q1 pairs (optionally half-cycle slipped) and queues it in a 2-entry buffer.
module ddr_rd_capture #(
  parameter int unsigned DQ_W      = 16,
  parameter int unsigned BURST_LEN = 8,
  parameter int unsigned LAT_W     = 5
) (
  input logic             CLK,
  input logic             RST_N,
  ddr_rd_capture_if.slave bus
);
  localparam int unsigned NB = BURST_LEN / 2;
  localparam int unsigned CW = (NB > 1) ? $clog2(NB) : 1;
  localparam int unsigned DL = (1 << LAT_W) - 1;
  localparam int unsigned WW = DQ_W * BURST_LEN;
  localparam int unsigned PW = 2 * DQ_W;
  localparam logic [CW-1:0] LAST = CW'(NB - 1);

  typedef enum logic {IDLE, CAPT} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DL-1:0]   sr_q, sr_d;
  logic [DQ_W-1:0] q1h_q, q1h_d;
  logic [WW-1:0]   asm_q, asm_d;
  logic [WW-1:0]   ent0_q, ent0_d;
  logic [WW-1:0]   ent1_q, ent1_d;
  logic [1:0]      fcnt_q, fcnt_d;
  logic            busy_q, busy_d;
  logic            ovf_q, ovf_d;
  logic            perr_q, perr_d;

  logic [LAT_W-1:0] tap;
  logic             start;
  logic             done;
  logic             err;
  logic             pop;
  logic             drop;
  logic [PW-1:0]    pair;
  logic [WW-1:0]    asm_w;
  int unsigned      beat_idx;

  always_comb begin
    // Bits beyond the active tap are cleared so the shift register only holds
    // commands still waiting for their window, which makes |sr a pending flag.
    tap   = (bus.RD_LAT == '0) ? '0 : bus.RD_LAT - 1'b1;
    start = sr_q[tap];
    sr_d  = {sr_q[DL-2:0], bus.RD_CMD};
    for (int unsigned i = 0; i < DL; i++) begin
      if (LAT_W'(i) > tap) sr_d[i] = 1'b0;
    end

    q1h_d = bus.Q1;
    pair  = bus.SLIP ? {bus.Q0, q1h_q} : {bus.Q1, bus.Q0};

    beat_idx = (state_q == CAPT) ? int'(cnt_q) : 0;
    asm_w    = asm_q;
    asm_w[beat_idx*PW +: PW] = pair;

    done = (state_q == CAPT) && (cnt_q == LAST);
    err  = start && (state_q == CAPT) && (cnt_q != LAST);

    // A start always claims this cycle's pair as beat 0 of a fresh burst.
    asm_d = asm_w;
    if (start) asm_d[PW-1:0] = pair;

    state_d = state_q;
    cnt_d   = cnt_q;
    if (start) begin
      state_d = CAPT;
      cnt_d   = CW'(1);
    end else if (done) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (state_q == CAPT) begin
      cnt_d = cnt_q + 1'b1;
    end

    pop    = (fcnt_q != '0) && bus.RREADY;
    drop   = 1'b0;
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    fcnt_d = fcnt_q;
    if (pop) begin
      ent0_d = ent1_q;
      fcnt_d = fcnt_q - 1'b1;
    end
    if (done) begin
      if (fcnt_d == 2'd2) begin
        drop = 1'b1;
      end else if (fcnt_d == 2'd0) begin
        ent0_d = asm_w;
        fcnt_d = 2'd1;
      end else begin
        ent1_d = asm_w;
        fcnt_d = 2'd2;
      end
    end

    ovf_d  = bus.CLR_FLAGS ? 1'b0 : ovf_q;
    perr_d = bus.CLR_FLAGS ? 1'b0 : perr_q;
    if (drop) ovf_d  = 1'b1;
    if (err)  perr_d = 1'b1;

    busy_d = (|sr_d) || (state_d == CAPT) || (fcnt_d != '0);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      q1h_q   <= '0;
      asm_q   <= '0;
      ent0_q  <= '0;
      ent1_q  <= '0;
      fcnt_q  <= '0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      q1h_q   <= q1h_d;
      asm_q   <= asm_d;
      ent0_q  <= ent0_d;
      ent1_q  <= ent1_d;
      fcnt_q  <= fcnt_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
      perr_q  <= perr_d;
    end
  end

  assign bus.RDATA     = ent0_q;
  assign bus.RVALID    = (fcnt_q != '0);
  assign bus.BUSY      = busy_q;
  assign bus.OVERFLOW  = ovf_q;
  assign bus.PROTO_ERR = perr_q;
endmodule

// File: tb/tb_ddr_rd_capture.sv
// Bench for ddr_rd_capture: directed test-plan scenarios plus randomized traffic,
// all checked against a time-indexed burst model.
module tb_ddr_rd_capture;
  localparam int DQ_W  = 16;
  localparam int BL    = 8;
  localparam int LAT_W = 5;
  localparam int NB    = BL / 2;
  localparam int W     = DQ_W * BL;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ddr_rd_capture_if #(.DQ_W(DQ_W), .BURST_LEN(BL), .LAT_W(LAT_W)) bus ();

  ddr_rd_capture #(.DQ_W(DQ_W), .BURST_LEN(BL), .LAT_W(LAT_W)) dut (
    .CLK  (clk),
    .RST_N(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", tag, act, exp);
    end
  endtask

  // Reference model: data history by cycle, pending window starts, output queue.
  int              now = 0;
  int              starts[$];
  logic [W-1:0]    expq[$];
  bit              m_active;
  int              m_cs;
  bit              m_ovf, m_perr, m_busy;
  logic [DQ_W-1:0] q0h[int];
  logic [DQ_W-1:0] q1h[int];
  int              lat = 5;
  bit              slip = 1'b0;

  bit              d_cmd = 1'b0, d_rready = 1'b0, d_clr = 1'b0;
  logic [DQ_W-1:0] d_q0 = '0, d_q1 = '0;

  function automatic logic [W-1:0] build_word(input int cs);
    logic [W-1:0]    w;
    logic [DQ_W-1:0] prev;
    w = '0;
    for (int k = 0; k < NB; k++) begin
      prev = q1h.exists(cs + k - 1) ? q1h[cs + k - 1] : '0;
      if (slip) begin
        w[(2*k)*DQ_W +: DQ_W]   = prev;
        w[(2*k+1)*DQ_W +: DQ_W] = q0h[cs + k];
      end else begin
        w[(2*k)*DQ_W +: DQ_W]   = q0h[cs + k];
        w[(2*k+1)*DQ_W +: DQ_W] = q1h[cs + k];
      end
    end
    return w;
  endfunction

  task automatic model_reset();
    starts.delete();
    expq.delete();
    m_active = 1'b0;
    m_ovf    = 1'b0;
    m_perr   = 1'b0;
    m_busy   = 1'b0;
  endtask

  // Called at a falling edge: check current outputs, apply this cycle's inputs,
  // advance the model across the coming rising edge.
  task automatic step();
    bit           pop, start, complete, err, drop;
    int           le;
    logic [W-1:0] word;
    check_eq("rvalid", W'(bus.RVALID), W'(expq.size() != 0));
    if (expq.size() != 0) check_eq("rdata", bus.RDATA, expq[0]);
    check_eq("busy", W'(bus.BUSY), W'(m_busy));
    check_eq("overflow", W'(bus.OVERFLOW), W'(m_ovf));
    check_eq("proto_err", W'(bus.PROTO_ERR), W'(m_perr));

    bus.RD_CMD    = d_cmd;
    bus.RD_LAT    = LAT_W'(lat);
    bus.SLIP      = slip;
    bus.Q0        = d_q0;
    bus.Q1        = d_q1;
    bus.RREADY    = d_rready;
    bus.CLR_FLAGS = d_clr;

    le = (lat == 0) ? 1 : lat;
    q0h[now] = d_q0;
    q1h[now] = d_q1;
    pop   = (expq.size() != 0) && d_rready;
    start = (starts.size() != 0) && (starts[0] == now);
    if (start) void'(starts.pop_front());
    if (d_cmd) starts.push_back(now + le);
    complete = m_active && (now == m_cs + NB - 1);
    err      = start && m_active && !complete;
    word     = '0;
    if (complete) word = build_word(m_cs);
    if (start) begin
      m_active = 1'b1;
      m_cs     = now;
    end else if (complete) begin
      m_active = 1'b0;
    end
    if (pop) void'(expq.pop_front());
    drop = 1'b0;
    if (complete) begin
      if (expq.size() < 2) expq.push_back(word);
      else drop = 1'b1;
    end
    if (d_clr) begin
      m_ovf  = 1'b0;
      m_perr = 1'b0;
    end
    if (drop) m_ovf = 1'b1;
    if (err) m_perr = 1'b1;
    m_busy = (starts.size() != 0) || m_active || (expq.size() != 0);

    @(negedge clk);
    now++;
    d_cmd = 1'b0;
    d_clr = 1'b0;
    d_q0  = DQ_W'($urandom);
    d_q1  = DQ_W'($urandom);
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    bus.RD_CMD    = 1'b0;
    bus.RREADY    = 1'b0;
    bus.CLR_FLAGS = 1'b0;
    model_reset();
    repeat (2) begin
      @(negedge clk);
      now++;
    end
    rst_n = 1'b1;
  endtask

  task automatic directed_read(input bit s, input string tag, input logic [W-1:0] exp_word);
    int seen;
    seen     = -1;
    lat      = 5;
    slip     = s;
    d_rready = 1'b1;
    for (int r = 0; r < 16; r++) begin
      if (bus.RVALID && seen < 0) begin
        seen = r;
        check_eq({tag, "_word"}, bus.RDATA, exp_word);
      end
      if (r == 10) check_eq({tag, "_busy_after_pop"}, W'(bus.BUSY), '0);
      d_cmd = (r == 0);
      if (r >= 5 && r <= 8) begin
        d_q0 = DQ_W'(16'h1000 + 2 * (r - 5));
        d_q1 = d_q0 + 1'b1;
      end
      if (r == 4) d_q1 = 16'hAAAA;
      step();
    end
    check_eq({tag, "_latency"}, W'(seen), W'(9));
  endtask

  task automatic run_seq(input logic [31:0] cmask, input bit rdy, input int ncyc,
                         output int first_v, output int nw, output int first_pe);
    first_v  = -1;
    first_pe = -1;
    nw       = 0;
    d_rready = rdy;
    for (int r = 0; r < ncyc; r++) begin
      if (bus.RVALID && first_v < 0) first_v = r;
      if (bus.PROTO_ERR && first_pe < 0) first_pe = r;
      if (bus.RVALID && rdy) nw++;
      d_cmd = (r < 32) ? cmask[r] : 1'b0;
      step();
    end
  endtask

  task automatic drain();
    d_rready = 1'b1;
    for (int i = 0; i < 200 && (m_busy || bus.BUSY); i++) step();
    check_eq("drain_idle", W'(bus.BUSY), '0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1);
  end

  initial begin
    int fv, nw, fp, since;
    d_q0 = '0;
    d_q1 = '0;
    bus.RD_LAT = LAT_W'(5);
    bus.SLIP   = 1'b0;
    bus.Q0     = '0;
    bus.Q1     = '0;
    do_reset();
    check_eq("reset_rvalid", W'(bus.RVALID), '0);
    check_eq("reset_rdata", bus.RDATA, '0);
    check_eq("reset_busy", W'(bus.BUSY), '0);

    directed_read(1'b0, "single", 128'h1007_1006_1005_1004_1003_1002_1001_1000);
    directed_read(1'b1, "slip", 128'h1006_1005_1004_1003_1002_1001_1000_AAAA);

    slip = 1'b0;
    lat  = 5;
    run_seq(32'h0000_0011, 1'b1, 20, fv, nw, fp);
    check_eq("b2b_first_valid", W'(fv), W'(9));
    check_eq("b2b_words", W'(nw), W'(2));
    check_eq("b2b_no_perr", W'(fp), W'(-1));

    run_seq(32'h0000_0005, 1'b1, 20, fv, nw, fp);
    check_eq("ovl_perr_cycle", W'(fp), W'(8));
    check_eq("ovl_valid_cycle", W'(fv), W'(11));
    check_eq("ovl_words", W'(nw), W'(1));
    d_clr = 1'b1;
    step();

    run_seq(32'h0000_0111, 1'b0, 24, fv, nw, fp);
    check_eq("bp_overflow", W'(bus.OVERFLOW), W'(1));
    run_seq(32'h0, 1'b1, 6, fv, nw, fp);
    check_eq("bp_words", W'(nw), W'(2));
    d_clr = 1'b1;
    step();
    check_eq("bp_clr", W'(bus.OVERFLOW), '0);

    run_seq(32'h1, 1'b1, 7, fv, nw, fp);
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_rvalid", W'(bus.RVALID), '0);
    check_eq("rst_mid_rdata", bus.RDATA, '0);
    check_eq("rst_mid_busy", W'(bus.BUSY), '0);
    check_eq("rst_mid_flags", W'({bus.OVERFLOW, bus.PROTO_ERR}), '0);
    @(negedge clk);
    now++;
    do_reset();
    run_seq(32'h0, 1'b1, 20, fv, nw, fp);
    check_eq("rst_no_word", W'(nw), '0);

    for (int ph = 0; ph < 6; ph++) begin
      drain();
      lat   = $urandom_range(31, 0);
      slip  = 1'(ph % 2);
      since = NB;
      for (int c = 0; c < 160; c++) begin
        d_cmd    = ((since >= NB) && ($urandom_range(2, 0) == 0)) || ($urandom_range(50, 0) == 0);
        since    = d_cmd ? 1 : since + 1;
        d_rready = (ph < 3) ? ($urandom_range(9, 0) != 0) : ($urandom_range(9, 0) < 4);
        d_clr    = ($urandom_range(30, 0) == 0);
        step();
      end
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
